// File: rtl/result_stream_m00_axis.sv
// result_stream_m00_axis: AXI-Stream master that drains result BRAM words
// 0..count-1 as one packet, with TLAST on the final beat.
// A 2-entry output buffer absorbs the 1-cycle BRAM read latency and TREADY stalls.
// Optional feature macro: RESULT_ROW_MARK_EN (adds M_AXIS_TUSER row-end marks).
module result_stream_m00_axis #(
  parameter int BRAM_DEPTH           = 10,
  parameter int C_M_AXIS_TDATA_WIDTH = 32
) (
  input  logic                              M_AXIS_ACLK,
  input  logic                              M_AXIS_ARESETN,
  input  logic                              start,
  input  logic [BRAM_DEPTH:0]               word_count,
  input  logic [31:0]                       row_width,
  output logic                              busy,
  output logic                              done,
  output logic [BRAM_DEPTH-1:0]             res_addr,
  output logic                              res_en,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   res_dout,
  output logic                              M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
`ifdef RESULT_ROW_MARK_EN
  output logic                              M_AXIS_TUSER,
`endif
  input  logic                              M_AXIS_TREADY
);

  localparam int CW = BRAM_DEPTH + 1;
  localparam int W  = C_M_AXIS_TDATA_WIDTH;
  localparam logic [CW-1:0] MAX_COUNT = {1'b1, {BRAM_DEPTH{1'b0}}};
  localparam logic [CW-1:0] ONE       = {{BRAM_DEPTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] reads_q, reads_d;
  logic [CW-1:0] beats_q, beats_d;
  logic          inflight_q, inflight_d;
  logic [1:0]    occ_q, occ_d;
  logic [W-1:0]  slot0_q, slot0_d;
  logic [W-1:0]  slot1_q, slot1_d;

  logic          pop;
  logic          push;
  logic          last_beat;
  logic          issue;
  logic [2:0]    level;

  // State, counters and the output buffer; reset clears everything at once.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      reads_q    <= '0;
      beats_q    <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      slot0_q    <= '0;
      slot1_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reads_q    <= reads_d;
      beats_q    <= beats_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
    end
  end

  // Next-state logic: read issue throttled so buffered + in-flight words never exceed 2.
  always_comb begin
    pop       = (occ_q != 2'd0) && M_AXIS_TREADY;
    push      = inflight_q;
    last_beat = (beats_q == (count_q - ONE));
    level     = {1'b0, occ_q} + {2'b00, inflight_q};
    issue     = (state_q == S_STREAM) && (reads_q < count_q) &&
                (level < (3'd2 + {2'b00, pop}));

    state_d    = state_q;
    count_d    = count_q;
    reads_d    = reads_q + (issue ? ONE : '0);
    beats_d    = beats_q + (pop ? ONE : '0);
    inflight_d = issue;
    occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
    slot0_d    = slot0_q;
    slot1_d    = slot1_q;

    // slot0 is always the head (the word presented on TDATA)
    if (pop) begin
      if (occ_q == 2'd2) begin
        slot0_d = slot1_q;
        if (push) slot1_d = res_dout;
      end else if (push) begin
        slot0_d = res_dout;
      end
    end else if (push) begin
      if (occ_q == 2'd0) slot0_d = res_dout;
      else               slot1_d = res_dout;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d = (word_count > MAX_COUNT) ? MAX_COUNT : word_count;
          state_d = (word_count == '0) ? S_DONE : S_STREAM;
        end
      end
      S_STREAM: begin
        if (pop && last_beat) state_d = S_DONE;
      end
      S_DONE: begin
        // clear so the next packet starts at address 0
        state_d = S_IDLE;
        reads_d = '0;
        beats_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy          = (state_q == S_STREAM);
  assign done          = (state_q == S_DONE);
  assign res_en        = issue;
  assign res_addr      = reads_q[BRAM_DEPTH-1:0];
  assign M_AXIS_TVALID = (occ_q != 2'd0);
  assign M_AXIS_TDATA  = slot0_q;
  assign M_AXIS_TSTRB  = '1;
  assign M_AXIS_TLAST  = M_AXIS_TVALID && last_beat;

`ifdef RESULT_ROW_MARK_EN
  logic [31:0] row_w_q, row_w_d;
  logic [31:0] row_cnt_q, row_cnt_d;
  logic        row_end;

  // Row width latch and position-within-row counter.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      row_w_q   <= '0;
      row_cnt_q <= '0;
    end else begin
      row_w_q   <= row_w_d;
      row_cnt_q <= row_cnt_d;
    end
  end

  // A row ends on beat k*row_width-1; width 0 disables row marks.
  always_comb begin
    row_end   = (row_w_q != 32'd0) && (row_cnt_q == (row_w_q - 32'd1));
    row_w_d   = row_w_q;
    row_cnt_d = row_cnt_q;
    if ((state_q == S_IDLE) && start) begin
      row_w_d   = row_width;
      row_cnt_d = '0;
    end else if (pop) begin
      row_cnt_d = row_end ? 32'd0 : (row_cnt_q + 32'd1);
    end
  end

  assign M_AXIS_TUSER = M_AXIS_TVALID && (last_beat || row_end);
`else
  logic unused_row_width;
  assign unused_row_width = ^row_width;
`endif

endmodule
